redirect_ctrl: RTL and testbench

Control-transfer scheduler for the decode stage. Evaluates J, JR, JAL, JALR and the four zero-compare branches, and computes the target. For a taken transfer, it drives a registered redirect request to fetch with a valid/ready handshake, flushes wrong-path fetch slots, and stalls decode until fetch resumes on the new path. It also produces the R7 link write for JAL/JALR.

---
 rtl/redirect_pkg.sv | 20 ++
 rtl/redirect_ctrl_if.sv | 21 ++
 rtl/redirect_target.sv | 57 +++++
 rtl/redirect_ctrl.sv | 117 +++++++++++
 tb/tb_redirect_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/redirect_pkg.sv
// Shared definitions for the decode-stage control-transfer scheduler:
// control-transfer opcodes and the scheduler state encoding.
package redirect_pkg;

    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_BLTZ = 5'b01110;
    localparam logic [4:0] OP_BGEZ = 5'b01111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

endpackage

// File: rtl/redirect_ctrl_if.sv
// Redirect request channel from decode to fetch: valid/ready handshake
// carrying the new fetch PC. The scheduler is the master, fetch the slave.
interface redirect_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              redirect_valid;
    logic              redirect_ready;
    logic [DATA_W-1:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/redirect_target.sv
// Combinational decode of control-transfer opcodes: decides whether the
// transfer is taken, whether it writes the link register, and its target.
// Assumes DATA_W >= 11 so both displacements can be sign-extended.
module redirect_target
    import redirect_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] pc_inc,
    input  logic [10:0]       disp11,
    input  logic [7:0]        imm8,
    input  logic [DATA_W-1:0] rs_val,
    output logic              taken,
    output logic              is_link,
    output logic [DATA_W-1:0] target
);

    logic [DATA_W-1:0] sext_disp11;
    logic [DATA_W-1:0] sext_imm8;

    assign sext_disp11 = {{(DATA_W-11){disp11[10]}}, disp11};
    assign sext_imm8   = {{(DATA_W-8){imm8[7]}}, imm8};

    // Taken/link decision and target adder; sums wrap modulo 2^DATA_W.
    always_comb begin
        taken   = 1'b0;
        is_link = 1'b0;
        target  = pc_inc + sext_imm8;
        case (opcode)
            OP_J: begin
                taken  = 1'b1;
                target = pc_inc + sext_disp11;
            end
            OP_JAL: begin
                taken   = 1'b1;
                is_link = 1'b1;
                target  = pc_inc + sext_disp11;
            end
            OP_JR: begin
                taken  = 1'b1;
                target = rs_val + sext_imm8;
            end
            OP_JALR: begin
                taken   = 1'b1;
                is_link = 1'b1;
                target  = rs_val + sext_imm8;
            end
            OP_BEQZ: taken = (rs_val == '0);
            OP_BNEZ: taken = (rs_val != '0);
            OP_BLTZ: taken = rs_val[DATA_W-1];
            OP_BGEZ: taken = ~rs_val[DATA_W-1];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/redirect_ctrl.sv
// Decode-stage control-transfer scheduler. On a taken transfer it issues a
// registered redirect to fetch, flushes IF/ID and stalls decode until the
// redirect is accepted and FLUSH_CYC bubble cycles have elapsed. JAL/JALR
// also emit a one-cycle R7 link write of PC+2.
// Optional build macro: REDIRECT_STATS_EN adds taken_cnt / wait_cnt.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | sampling decode; no transfer in flight
//   REDIRECT | redirect_valid held high until fetch takes it
//   FLUSH    | FLUSH_CYC bubble cycles after acceptance, decode stalled
module redirect_ctrl
    import redirect_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FLUSH_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_opcode,
    input  logic [DATA_W-1:0] id_pc_inc,
    input  logic [10:0]       id_disp11,
    input  logic [7:0]        id_imm8,
    input  logic [DATA_W-1:0] id_rs_val,
    redirect_ctrl_if.master   rdr,
    output logic              flush_if,
    output logic              id_stall,
    output logic              link_we,
    output logic [DATA_W-1:0] link_data
`ifdef REDIRECT_STATS_EN
    ,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       wait_cnt
`endif
);

    state_t            state;
    logic [2:0]        flush_cnt;
    logic [DATA_W-1:0] pc_q;
    logic              taken;
    logic              is_link;
    logic [DATA_W-1:0] target;
    logic              start;

    redirect_target #(.DATA_W(DATA_W)) u_target (
        .opcode  (id_opcode),
        .pc_inc  (id_pc_inc),
        .disp11  (id_disp11),
        .imm8    (id_imm8),
        .rs_val  (id_rs_val),
        .taken   (taken),
        .is_link (is_link),
        .target  (target)
    );

    assign start = (state == IDLE) && id_valid && taken;

    // Scheduler FSM with its captured target, link strobe and bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc_q      <= '0;
            link_we   <= 1'b0;
            link_data <= '0;
            flush_cnt <= '0;
        end else begin
            link_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REDIRECT;
                        pc_q      <= target;
                        link_data <= id_pc_inc;
                        link_we   <= is_link;
                        flush_cnt <= 3'(FLUSH_CYC);
                    end
                end
                REDIRECT: begin
                    if (rdr.redirect_ready) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rdr.redirect_valid = (state == REDIRECT);
    assign rdr.redirect_pc    = pc_q;
    assign flush_if           = (state != IDLE);
    assign id_stall           = (state != IDLE);

`ifdef REDIRECT_STATS_EN
    // Saturating counters of taken transfers and stalled redirect cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (start && (taken_cnt != 16'hFFFF)) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
            if ((state == REDIRECT) && !rdr.redirect_ready && (wait_cnt != 16'hFFFF)) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Self-checking bench for redirect_ctrl: directed vector table, a reset
// sequence during REDIRECT, and randomized transfers against a model.
module tb_redirect_ctrl;

    localparam int DATA_W    = 16;
    localparam int FLUSH_CYC = 1;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_opcode;
    logic [15:0] id_pc_inc;
    logic [10:0] id_disp11;
    logic [7:0]  id_imm8;
    logic [15:0] id_rs_val;
    logic        flush_if;
    logic        id_stall;
    logic        link_we;
    logic [15:0] link_data;
`ifdef REDIRECT_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] wait_cnt;
`endif

    redirect_ctrl_if #(.DATA_W(DATA_W)) rdr ();

    redirect_ctrl #(.DATA_W(DATA_W), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_opcode (id_opcode),
        .id_pc_inc (id_pc_inc),
        .id_disp11 (id_disp11),
        .id_imm8   (id_imm8),
        .id_rs_val (id_rs_val),
        .rdr       (rdr.master),
        .flush_if  (flush_if),
        .id_stall  (id_stall),
        .link_we   (link_we),
        .link_data (link_data)
`ifdef REDIRECT_STATS_EN
        ,
        .taken_cnt (taken_cnt),
        .wait_cnt  (wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [15:0] last_pc = 16'h0;
    int m_taken = 0;
    int m_waits = 0;

    typedef struct {
        logic        vld;
        logic [4:0]  op;
        logic [15:0] pcinc;
        logic [10:0] disp;
        logic [7:0]  imm;
        logic [15:0] rs;
        int          waits;
        logic        taken;
        logic [15:0] tgt;
        logic        link;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: architectural rules with plain integer arithmetic.
    function automatic void ref_model(input logic vld, input logic [4:0] op,
                                      input logic [15:0] pcinc, input logic [10:0] disp,
                                      input logic [7:0] imm, input logic [15:0] rs,
                                      output logic taken, output logic [15:0] tgt,
                                      output logic link);
        int d, i, sum;
        d = disp[10] ? int'(disp) - 2048 : int'(disp);
        i = imm[7] ? int'(imm) - 256 : int'(imm);
        taken = 1'b0;
        link  = 1'b0;
        sum   = int'(pcinc) + i;
        case (int'(op))
            4:  begin taken = 1'b1; sum = int'(pcinc) + d; end
            6:  begin taken = 1'b1; link = 1'b1; sum = int'(pcinc) + d; end
            5:  begin taken = 1'b1; sum = int'(rs) + i; end
            7:  begin taken = 1'b1; link = 1'b1; sum = int'(rs) + i; end
            12: taken = (int'(rs) == 0);
            13: taken = (int'(rs) != 0);
            14: taken = (int'(rs) >= 32768);
            15: taken = (int'(rs) < 32768);
            default: taken = 1'b0;
        endcase
        if (!vld) begin
            taken = 1'b0;
            link  = 1'b0;
        end
        tgt = 16'((sum % 65536 + 65536) % 65536);
    endfunction

    // Drive one decode instruction at a negedge and follow it until decode is
    // released; returns at a negedge with the DUT back in IDLE.
    task automatic xfer(input vec_t v);
        int n_stall, n_valid, n_link, pc_bad;
        id_valid  = v.vld;
        id_opcode = v.op;
        id_pc_inc = v.pcinc;
        id_disp11 = v.disp;
        id_imm8   = v.imm;
        id_rs_val = v.rs;
        rdr.redirect_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (!v.taken) begin
            check({v.name, ".valid"}, 32'(rdr.redirect_valid), 32'd0);
            check({v.name, ".stall"}, 32'(id_stall), 32'd0);
            check({v.name, ".link_we"}, 32'(link_we), 32'd0);
            check({v.name, ".pc_hold"}, 32'(rdr.redirect_pc), 32'(last_pc));
            id_valid = 1'b0;
        end else begin
            check({v.name, ".valid"}, 32'(rdr.redirect_valid), 32'd1);
            check({v.name, ".pc"}, 32'(rdr.redirect_pc), 32'(v.tgt));
            check({v.name, ".link_we"}, 32'(link_we), 32'(v.link));
            check({v.name, ".link_data"}, 32'(link_data), 32'(v.pcinc));
            check({v.name, ".flush_if"}, 32'(flush_if), 32'd1);
            last_pc = v.tgt;
            m_taken++;
            m_waits += v.waits;
            n_stall = 1;
            n_valid = 1;
            n_link  = int'(link_we);
            pc_bad  = 0;
            for (int c = 0; c < 64; c++) begin
                rdr.redirect_ready = (c >= v.waits);
                if (c >= v.waits) begin
                    id_valid = 1'b0;
                end else begin
                    id_valid  = 1'b1;
                    id_opcode = 5'b00110;
                    id_pc_inc = 16'($urandom);
                    id_disp11 = 11'($urandom);
                    id_imm8   = 8'($urandom);
                    id_rs_val = 16'($urandom);
                end
                @(negedge clk);
                if (!id_stall) break;
                n_stall++;
                if (rdr.redirect_valid) begin
                    n_valid++;
                    if (rdr.redirect_pc !== v.tgt) pc_bad++;
                end
                n_link += int'(link_we);
            end
            rdr.redirect_ready = 1'b0;
            id_valid = 1'b0;
            check({v.name, ".stall_cycles"}, 32'(n_stall), 32'(1 + v.waits + FLUSH_CYC));
            check({v.name, ".valid_cycles"}, 32'(n_valid), 32'(1 + v.waits));
            check({v.name, ".link_pulses"}, 32'(n_link), 32'(v.link));
            check({v.name, ".pc_stable"}, 32'(pc_bad), 32'd0);
            check({v.name, ".flush_end"}, 32'(flush_if), 32'd0);
        end
    endtask

    initial begin
        vec_t rv;
        logic [4:0] ops[10];
        rst_n = 1'b0;
        id_valid = 1'b0;
        id_opcode = '0;
        id_pc_inc = '0;
        id_disp11 = '0;
        id_imm8 = '0;
        id_rs_val = '0;
        rdr.redirect_ready = 1'b0;

        //            vld  op        pcinc     disp     imm     rs       w  tk   tgt       lnk
        vecs[0]  = '{1'b1, 5'b00100, 16'h0010, 11'h7FE, 8'h00, 16'h0000, 0, 1'b1, 16'h000E, 1'b0, "j_back"};
        vecs[1]  = '{1'b1, 5'b00111, 16'h0200, 11'h000, 8'h80, 16'h1234, 0, 1'b1, 16'h11B4, 1'b1, "jalr"};
        vecs[2]  = '{1'b1, 5'b01100, 16'h0100, 11'h000, 8'h04, 16'h0000, 0, 1'b1, 16'h0104, 1'b0, "beqz_tk"};
        vecs[3]  = '{1'b1, 5'b01101, 16'h0100, 11'h000, 8'h04, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, "bnez_nt"};
        vecs[4]  = '{1'b1, 5'b01110, 16'h0100, 11'h000, 8'h04, 16'h8000, 0, 1'b1, 16'h0104, 1'b0, "bltz_tk"};
        vecs[5]  = '{1'b1, 5'b00100, 16'h0040, 11'h010, 8'h00, 16'h0000, 3, 1'b1, 16'h0050, 1'b0, "j_wait3"};
        vecs[6]  = '{1'b1, 5'b00100, 16'hFFFE, 11'h004, 8'h00, 16'h0000, 0, 1'b1, 16'h0002, 1'b0, "j_wrap"};
        vecs[7]  = '{1'b1, 5'b00110, 16'h0300, 11'h3FF, 8'h00, 16'h0000, 1, 1'b1, 16'h06FF, 1'b1, "jal_wait1"};
        vecs[8]  = '{1'b1, 5'b00101, 16'h0700, 11'h000, 8'h7F, 16'h1000, 0, 1'b1, 16'h107F, 1'b0, "jr"};
        vecs[9]  = '{1'b1, 5'b01111, 16'h0100, 11'h000, 8'h04, 16'h8000, 0, 1'b0, 16'h0000, 1'b0, "bgez_nt"};
        vecs[10] = '{1'b1, 5'b01111, 16'h0100, 11'h000, 8'hFC, 16'h7FFF, 0, 1'b1, 16'h00FC, 1'b0, "bgez_tk"};
        vecs[11] = '{1'b1, 5'b00000, 16'h0100, 11'h010, 8'h10, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, "other_op"};
        vecs[12] = '{1'b0, 5'b00100, 16'h0100, 11'h010, 8'h10, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, "valid_low"};
        vecs[13] = '{1'b1, 5'b01101, 16'h0100, 11'h000, 8'h10, 16'h0001, 0, 1'b1, 16'h0110, 1'b0, "bnez_tk"};

        #12;
        check("rst.valid", 32'(rdr.redirect_valid), 32'd0);
        check("rst.pc", 32'(rdr.redirect_pc), 32'd0);
        check("rst.stall", 32'(id_stall), 32'd0);
        check("rst.link_data", 32'(link_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 14; k++) xfer(vecs[k]);

        // Reset pulsed while a JAL redirect is pending.
        id_valid  = 1'b1;
        id_opcode = 5'b00110;
        id_pc_inc = 16'h0500;
        id_disp11 = 11'h010;
        id_imm8   = 8'h00;
        id_rs_val = 16'h0000;
        @(negedge clk);
        id_valid = 1'b0;
        rdr.redirect_ready = 1'b0;
        check("rstmid.pre_valid", 32'(rdr.redirect_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid.valid", 32'(rdr.redirect_valid), 32'd0);
        check("rstmid.stall", 32'(id_stall), 32'd0);
        check("rstmid.flush", 32'(flush_if), 32'd0);
        check("rstmid.link_we", 32'(link_we), 32'd0);
        check("rstmid.link_data", 32'(link_data), 32'd0);
        check("rstmid.pc", 32'(rdr.redirect_pc), 32'd0);
`ifdef REDIRECT_STATS_EN
        check("rstmid.taken_cnt", 32'(taken_cnt), 32'd0);
        check("rstmid.wait_cnt", 32'(wait_cnt), 32'd0);
`endif
        m_taken = 0;
        m_waits = 0;
        last_pc = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid.idle_pc", 32'(rdr.redirect_pc), 32'd0);
        xfer(vecs[0]);

        // Randomized transfers against the reference model.
        ops = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01100,
                5'b01101, 5'b01110, 5'b01111, 5'b00000, 5'b11111};
        for (int n = 0; n < 40; n++) begin
            rv.vld   = ($urandom_range(0, 7) != 0);
            rv.op    = ops[$urandom_range(0, 9)];
            rv.pcinc = 16'($urandom);
            rv.disp  = 11'($urandom);
            rv.imm   = 8'($urandom);
            rv.rs    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            rv.waits = $urandom_range(0, 3);
            rv.name  = $sformatf("rnd%0d", n);
            ref_model(rv.vld, rv.op, rv.pcinc, rv.disp, rv.imm, rv.rs, rv.taken, rv.tgt, rv.link);
            xfer(rv);
        end

`ifdef REDIRECT_STATS_EN
        check("stats.taken_cnt", 32'(taken_cnt), 32'(m_taken));
        check("stats.wait_cnt", 32'(wait_cnt), 32'(m_waits));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
